ucode_port_arbiter: RTL and testbench

- Shares the single-ported microcode store between three requesters:
  - the control unit's normal micro-code fetch;
  - the control unit's speculative (fused) micro-code fetch;
  - the microcode loader's write port.
- Grants one RAM access per cycle and routes the 1-cycle-latency read data back to the requester that issued it.
- Honours pipeline flush and the all-ones NOP address convention.
- Bounds speculative-fetch starvation with an age counter.

---
 rtl/ucode_port_arbiter.sv | 118 +++++++++++
 tb/tb_ucode_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ucode_port_arbiter.sv
// Arbitrates the single-ported microcode store between normal fetch, speculative
// fetch and the loader, and steers the 1-cycle read data back to its owner.
module ucode_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_pipeline,
  input  logic              norm_req,
  input  logic [ADDR_W-1:0] norm_addr,
  output logic              norm_gnt,
  output logic              norm_rvalid,
  output logic [DATA_W-1:0] norm_rdata,
  input  logic              spec_req,
  input  logic [ADDR_W-1:0] spec_addr,
  output logic              spec_gnt,
  output logic              spec_rvalid,
  output logic [DATA_W-1:0] spec_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              spec_starved
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic       norm_nop, spec_nop, rd_ok;
  logic       norm_real, spec_real;
  logic       ld_win, norm_win, spec_win;
  logic [2:0] starve_cnt_reg, starve_cnt_next;

  assign norm_nop  = &norm_addr;
  assign spec_nop  = &spec_addr;
  assign rd_ok     = !rst && !flush_pipeline;
  assign norm_real = rd_ok && norm_req && !norm_nop;
  assign spec_real = rd_ok && spec_req && !spec_nop;

  assign spec_starved = (starve_cnt_reg == STARVE_LIM);

  // Loader always first; a starved speculative fetch then jumps ahead of normal.
  assign ld_win   = !rst && ld_req;
  assign spec_win = !ld_win && spec_real && (spec_starved || !norm_real);
  assign norm_win = !ld_win && norm_real && !spec_win;

  // NOP reads are granted outside arbitration and never touch the RAM.
  assign ld_gnt   = ld_win;
  assign norm_gnt = norm_win || (rd_ok && norm_req && norm_nop);
  assign spec_gnt = spec_win || (rd_ok && spec_req && spec_nop);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (ld_win) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = ld_addr;
      ram_wdata = ld_wdata;
    end else if (spec_win) begin
      ram_en   = 1'b1;
      ram_addr = spec_addr;
    end else if (norm_win) begin
      ram_en   = 1'b1;
      ram_addr = norm_addr;
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (flush_pipeline || !spec_req || spec_gnt)
      starve_cnt_next = 3'd0;
    else if (!spec_nop && !spec_starved)
      starve_cnt_next = starve_cnt_reg + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt_reg <= 3'd0;
    else     starve_cnt_reg <= starve_cnt_next;
  end

  // Read return: index 0 = normal, 1 = speculative.
  logic [1:0]        rd_gnt, rd_nop, rvalid_reg, nop_reg;
  logic [DATA_W-1:0] rd_data [2];

  assign rd_gnt = {spec_gnt, norm_gnt};
  assign rd_nop = {spec_nop, norm_nop};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      always_ff @(posedge clk) begin
        if (rst) begin
          rvalid_reg[gi] <= 1'b0;
          nop_reg[gi]    <= 1'b0;
        end else begin
          rvalid_reg[gi] <= rd_gnt[gi];
          nop_reg[gi]    <= rd_gnt[gi] && rd_nop[gi];
        end
      end
      // Masking with rst drops a result whose owner was reset mid-flight.
      assign rd_data[gi] = (rvalid_reg[gi] && !nop_reg[gi] && !rst) ? ram_rdata : '0;
    end
  endgenerate

  assign norm_rvalid = rvalid_reg[0] && !rst;
  assign spec_rvalid = rvalid_reg[1] && !rst;
  assign norm_rdata  = rd_data[0];
  assign spec_rdata  = rd_data[1];

endmodule

// File: tb/tb_ucode_port_arbiter.sv
// Directed bench for ucode_port_arbiter with a behavioural synchronous RAM.
module tb_ucode_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_pipeline;
  logic          norm_req, spec_req, ld_req;
  logic [AW-1:0] norm_addr, spec_addr, ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          norm_gnt, spec_gnt, ld_gnt;
  logic          norm_rvalid, spec_rvalid;
  logic [DW-1:0] norm_rdata, spec_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          spec_starved;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [256];

  ucode_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .flush_pipeline(flush_pipeline),
    .norm_req(norm_req), .norm_addr(norm_addr), .norm_gnt(norm_gnt),
    .norm_rvalid(norm_rvalid), .norm_rdata(norm_rdata),
    .spec_req(spec_req), .spec_addr(spec_addr), .spec_gnt(spec_gnt),
    .spec_rvalid(spec_rvalid), .spec_rdata(spec_rdata),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .spec_starved(spec_starved)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle and apply new inputs 1ns after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {24'hC0DE00, 8'(i)};
    mem[8'h10] = 32'h1234_5678;

    rst = 1'b1; flush_pipeline = 1'b0;
    norm_req = 1'b0; spec_req = 1'b0; ld_req = 1'b0;
    norm_addr = '0; spec_addr = '0; ld_addr = '0; ld_wdata = '0;

    // Reset state: requests present while rst=1 must not be granted.
    repeat (2) next_cycle();
    norm_req = 1'b1; norm_addr = 8'h10; ld_req = 1'b1;
    @(negedge clk);
    chk("rst_norm_gnt", {31'b0, norm_gnt}, 32'd0);
    chk("rst_ld_gnt",   {31'b0, ld_gnt},   32'd0);
    chk("rst_ram_en",   {31'b0, ram_en},   32'd0);
    chk("rst_ram_we",   {31'b0, ram_we},   32'd0);
    chk("rst_rvalid",   {30'b0, spec_rvalid, norm_rvalid}, 32'd0);
    chk("rst_starved",  {31'b0, spec_starved}, 32'd0);
    next_cycle();
    rst = 1'b0; ld_req = 1'b0;
    $display("txn reset: done");

    // Normal read of 0x10.
    @(negedge clk);
    chk("rd_norm_gnt", {31'b0, norm_gnt}, 32'd1);
    chk("rd_ram_en",   {31'b0, ram_en},   32'd1);
    chk("rd_ram_we",   {31'b0, ram_we},   32'd0);
    chk("rd_ram_addr", {24'b0, ram_addr}, 32'h10);
    next_cycle();
    norm_req = 1'b0;
    @(negedge clk);
    chk("rd_norm_rvalid", {31'b0, norm_rvalid}, 32'd1);
    chk("rd_norm_rdata",  norm_rdata, 32'h1234_5678);
    chk("rd_spec_rvalid", {31'b0, spec_rvalid}, 32'd0);
    chk("idle_ram_addr",  {24'b0, ram_addr}, 32'd0);
    chk("idle_ram_wdata", ram_wdata, 32'd0);
    $display("txn normal read 0x10: rdata=%08h", norm_rdata);

    // Starvation: norm and spec both held for 6 cycles.
    next_cycle();
    norm_req = 1'b1; norm_addr = 8'h30; spec_req = 1'b1; spec_addr = 8'h31;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("starve_norm_gnt_%0d", k), {31'b0, norm_gnt}, (k != 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve_spec_gnt_%0d", k), {31'b0, spec_gnt}, (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve_flag_%0d", k), {31'b0, spec_starved}, (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve_addr_%0d", k), {24'b0, ram_addr}, (k == 4) ? 32'h31 : 32'h30);
      if (k == 5) begin
        chk("starve_spec_rvalid", {31'b0, spec_rvalid}, 32'd1);
        chk("starve_spec_rdata",  spec_rdata, 32'hC0DE_0031);
        chk("starve_norm_rvalid", {31'b0, norm_rvalid}, 32'd0);
      end
      $display("txn starve cycle %0d: norm_gnt=%0b spec_gnt=%0b starved=%0b",
               k, norm_gnt, spec_gnt, spec_starved);
      next_cycle();
    end
    norm_req = 1'b0; spec_req = 1'b0;
    @(negedge clk);
    chk("starve_tail_rvalid", {31'b0, norm_rvalid}, 32'd1);
    chk("starve_tail_rdata",  norm_rdata, 32'hC0DE_0030);
    chk("starve_tail_flag",   {31'b0, spec_starved}, 32'd0);

    // Loader write 0xAA to 0x20 colliding with a normal read of 0x20.
    next_cycle();
    ld_req = 1'b1; ld_addr = 8'h20; ld_wdata = 32'hAA;
    norm_req = 1'b1; norm_addr = 8'h20;
    @(negedge clk);
    chk("wr_ld_gnt",    {31'b0, ld_gnt},   32'd1);
    chk("wr_ram_we",    {31'b0, ram_we},   32'd1);
    chk("wr_norm_gnt",  {31'b0, norm_gnt}, 32'd0);
    chk("wr_ram_wdata", ram_wdata, 32'hAA);
    next_cycle();
    ld_req = 1'b0;
    @(negedge clk);
    chk("wr_rd_gnt",    {31'b0, norm_gnt},    32'd1);
    chk("wr_rd_rvalid", {31'b0, norm_rvalid}, 32'd0);
    next_cycle();
    norm_req = 1'b0;
    @(negedge clk);
    chk("wr_rd_rvalid2", {31'b0, norm_rvalid}, 32'd1);
    chk("wr_rd_rdata",   norm_rdata, 32'hAA);
    $display("txn write-then-read 0x20: rdata=%08h", norm_rdata);

    // Speculative NOP alongside a normal read of 0x05.
    next_cycle();
    norm_req = 1'b1; norm_addr = 8'h05; spec_req = 1'b1; spec_addr = 8'hFF;
    @(negedge clk);
    chk("nop_norm_gnt", {31'b0, norm_gnt}, 32'd1);
    chk("nop_spec_gnt", {31'b0, spec_gnt}, 32'd1);
    chk("nop_ram_addr", {24'b0, ram_addr}, 32'h05);
    next_cycle();
    norm_req = 1'b0; spec_req = 1'b0;
    @(negedge clk);
    chk("nop_spec_rvalid", {31'b0, spec_rvalid}, 32'd1);
    chk("nop_spec_rdata",  spec_rdata, 32'd0);
    chk("nop_norm_rvalid", {31'b0, norm_rvalid}, 32'd1);
    chk("nop_norm_rdata",  norm_rdata, 32'hC0DE_0005);
    $display("txn spec NOP + norm 0x05: spec_rdata=%08h norm_rdata=%08h", spec_rdata, norm_rdata);

    // Both requesters NOP.
    next_cycle();
    norm_req = 1'b1; norm_addr = 8'hFF; spec_req = 1'b1; spec_addr = 8'hFF;
    @(negedge clk);
    chk("nop2_gnts",   {30'b0, spec_gnt, norm_gnt}, 32'd3);
    chk("nop2_ram_en", {31'b0, ram_en}, 32'd0);
    next_cycle();
    norm_req = 1'b0; spec_req = 1'b0;
    @(negedge clk);
    chk("nop2_rvalids", {30'b0, spec_rvalid, norm_rvalid}, 32'd3);
    chk("nop2_rdata",   norm_rdata | spec_rdata, 32'd0);
    $display("txn double NOP: rvalids=%0b%0b", spec_rvalid, norm_rvalid);

    // Flush after 3 denied spec cycles; the counter must clear.
    next_cycle();
    norm_req = 1'b1; norm_addr = 8'h30; spec_req = 1'b1; spec_addr = 8'h31;
    repeat (3) next_cycle();
    flush_pipeline = 1'b1; ld_req = 1'b1; ld_addr = 8'h40; ld_wdata = 32'hBEEF;
    @(negedge clk);
    chk("flush_ld_gnt",  {31'b0, ld_gnt}, 32'd1);
    chk("flush_rd_gnts", {30'b0, spec_gnt, norm_gnt}, 32'd0);
    chk("flush_ram_we",  {31'b0, ram_we}, 32'd1);
    next_cycle();
    flush_pipeline = 1'b0; ld_req = 1'b0;
    @(negedge clk);
    chk("flush_rvalids",  {30'b0, spec_rvalid, norm_rvalid}, 32'd0);
    chk("flush_starved",  {31'b0, spec_starved}, 32'd0);
    chk("flush_norm_gnt", {31'b0, norm_gnt}, 32'd1);
    $display("txn flush: starved=%0b norm_gnt=%0b", spec_starved, norm_gnt);
    next_cycle();
    norm_req = 1'b0; spec_req = 1'b0;

    // Reset the cycle after a read is granted.
    next_cycle();
    norm_req = 1'b1; norm_addr = 8'h10;
    @(negedge clk);
    chk("rstrd_gnt", {31'b0, norm_gnt}, 32'd1);
    next_cycle();
    rst = 1'b1; norm_req = 1'b0;
    @(negedge clk);
    chk("rstrd_rvalid_in_rst", {31'b0, norm_rvalid}, 32'd0);
    chk("rstrd_rdata_in_rst",  norm_rdata, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rstrd_rvalid_after", {30'b0, spec_rvalid, norm_rvalid}, 32'd0);
    chk("rstrd_rdata_after",  norm_rdata | spec_rdata, 32'd0);
    chk("rstrd_ram_en",       {31'b0, ram_en}, 32'd0);
    chk("rstrd_starved",      {31'b0, spec_starved}, 32'd0);
    $display("txn reset mid-read: norm_rvalid=%0b", norm_rvalid);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
